count_combiner: RTL and testbench

Multi-channel, pipelined successor to the single-channel coarse/fine count adder in the frequency-counter datapath. Each channel presents a coarse (reciprocal) count plus interpolator fine counts; the block buffers one sample per channel, arbitrates round-robin onto a single output stream, and forms `coarse * 2^FINE_BITS + fine` (legacy mode) or `coarse * 2^FINE_BITS + fine_start - fine_stop` (differential mode) with saturation. It sits between the per-channel gate/interpolator logic and the readout FIFO/bus interface.

---
 rtl/count_combiner_pkg.sv | 31 +++
 rtl/count_combiner_rr_arbiter.sv | 49 ++++
 rtl/count_combiner.sv | 139 +++++++++++++
 tb/tb_count_combiner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_combiner_pkg.sv
// Shared mode encoding and saturation helper for the coarse/fine count combiner.
package count_combiner_pkg;

  localparam logic MODE_LEGACY = 1'b0;
  localparam logic MODE_DIFF   = 1'b1;

  // Widest result the helper can clamp into; the signed intermediate carries two extra bits.
  localparam int SAT_MAX_W = 64;
  localparam int SAT_IN_W  = SAT_MAX_W + 2;

  typedef logic signed [SAT_IN_W-1:0] sat_in_t;
  typedef logic [SAT_MAX_W:0]         sat_out_t;

  // Returns {ovf, count}; count is zero-extended to SAT_MAX_W bits.
  function automatic sat_out_t sat_result(input sat_in_t sum, input int unsigned out_w);
    sat_in_t  lim;
    sat_out_t res;
    lim = (sat_in_t'(1) <<< out_w) - sat_in_t'(1);
    res = '0;
    if (sum > lim) begin
      res[SAT_MAX_W]     = 1'b1;
      res[SAT_MAX_W-1:0] = lim[SAT_MAX_W-1:0];
    end else if (sum < sat_in_t'(0)) begin
      res[SAT_MAX_W] = 1'b1;
    end else begin
      res[SAT_MAX_W-1:0] = sum[SAT_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/count_combiner_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rr pointer.
module rr_arbiter #(
  parameter  int NCH   = 4,
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic             en,
  output logic [NCH-1:0]   gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] rr_q, rr_d;

  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    c          = 0;
    ci         = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      c = int'(rr_q) + i;
      if (c >= NCH) c = c - NCH;
      ci = IDX_W'(c);
      if (en && !gnt_valid && req[ci]) begin
        gnt_valid      = 1'b1;
        gnt_idx        = ci;
        gnt_onehot[ci] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_valid) begin
      rr_d = (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/count_combiner.sv
// Multi-channel coarse/fine count combiner: per-channel one-deep holds, round-robin
// arbitration, and a saturating coarse*2^FINE_BITS + fine result register.
module count_combiner
  import count_combiner_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int COARSE_W  = 32,
  parameter  int FINE_BITS = 3,
  parameter  int FINE_W    = 4,
  parameter  int OUT_W     = 32,
  parameter  int DROP_W    = 8,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*COARSE_W-1:0] in_coarse,
  input  logic [NCH*FINE_W-1:0]   in_fine_start,
  input  logic [NCH*FINE_W-1:0]   in_fine_stop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_chan,
  output logic [OUT_W-1:0]        out_count,
  output logic                    out_ovf,
  output logic [NCH*DROP_W-1:0]   drop_count
);

  logic [NCH-1:0]      full_q, full_d, capture;
  logic [COARSE_W-1:0] coarse_q [NCH];
  logic [FINE_W-1:0]   start_q  [NCH];
  logic [FINE_W-1:0]   stop_q   [NCH];
  logic [DROP_W-1:0]   drop_q   [NCH];
  logic [DROP_W-1:0]   drop_d   [NCH];

  logic [NCH-1:0]  gnt_onehot;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_valid;

  logic             out_valid_q;
  logic [CH_W-1:0]  out_chan_q;
  logic [OUT_W-1:0] out_count_q;
  logic             out_ovf_q;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (full_q),
    .en         (!out_valid_q || out_ready),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid)
  );

  // ---- stage 0: per-channel hold registers and drop counters ----
  always_comb begin
    capture = '0;
    full_d  = '0;
    for (int c = 0; c < NCH; c++) begin
      // A hold being granted this cycle frees up in time to take the new sample.
      capture[c] = in_valid[c] && (!full_q[c] || gnt_onehot[c]);
      full_d[c]  = capture[c] || (full_q[c] && !gnt_onehot[c]);
      drop_d[c]  = drop_q[c];
      if (in_valid[c] && !capture[c] && (drop_q[c] != '1)) drop_d[c] = drop_q[c] + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      for (int c = 0; c < NCH; c++) drop_q[c] <= '0;
    end else begin
      full_q <= full_d;
      for (int c = 0; c < NCH; c++) drop_q[c] <= drop_d[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (capture[c]) begin
        coarse_q[c] <= in_coarse[c*COARSE_W +: COARSE_W];
        start_q[c]  <= in_fine_start[c*FINE_W +: FINE_W];
        stop_q[c]   <= in_fine_stop[c*FINE_W +: FINE_W];
      end
    end
  end

  // ---- stage 0 -> 1: arithmetic on the granted channel ----
  sat_in_t          coarse_s, start_s, stop_s, sum_s;
  sat_out_t         sat;
  logic [OUT_W-1:0] res_count;
  logic             res_ovf;

  always_comb begin
    coarse_s = '0;
    coarse_s[COARSE_W-1:0] = coarse_q[gnt_idx];
    coarse_s = coarse_s <<< FINE_BITS;
    start_s  = '0;
    start_s[FINE_W-1:0] = start_q[gnt_idx];
    stop_s   = '0;
    if (mode == MODE_DIFF) stop_s[FINE_W-1:0] = stop_q[gnt_idx];
    sum_s     = coarse_s + start_s - stop_s;
    sat       = sat_result(sum_s, OUT_W);
    res_count = sat[OUT_W-1:0];
    res_ovf   = sat[SAT_MAX_W];
  end

  if (OUT_W < SAT_MAX_W) begin : g_sat_pad
    logic sat_pad_unused;
    assign sat_pad_unused = ^sat[SAT_MAX_W-1:OUT_W];
  end

  // ---- stage 1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (gnt_valid) begin
      out_valid_q <= 1'b1;
      out_chan_q  <= gnt_idx;
      out_count_q <= res_count;
      out_ovf_q   <= res_ovf;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  for (genvar c = 0; c < NCH; c++) begin : g_drop
    assign drop_count[c*DROP_W +: DROP_W] = drop_q[c];
  end

endmodule

// File: tb/tb_count_combiner.sv
// Self-checking bench for count_combiner: directed scenarios plus randomized traffic
// compared against a behavioural model of holds, round-robin order and saturating math.
module tb_count_combiner;

  localparam int NCH = 4, COARSE_W = 32, FINE_BITS = 3, FINE_W = 4, OUT_W = 32, DROP_W = 8;
  localparam int CH_W = 2;

  logic clk = 1'b0;
  logic rst, mode, out_ready, out_valid, out_ovf;
  logic [NCH-1:0] in_valid;
  logic [NCH*COARSE_W-1:0] in_coarse;
  logic [NCH*FINE_W-1:0] in_fine_start, in_fine_stop;
  logic [CH_W-1:0] out_chan;
  logic [OUT_W-1:0] out_count;
  logic [NCH*DROP_W-1:0] drop_count;

  logic [COARSE_W-1:0] b_coarse [NCH];
  logic [FINE_W-1:0]   b_start  [NCH];
  logic [FINE_W-1:0]   b_stop   [NCH];

  always_comb begin
    in_coarse = '0; in_fine_start = '0; in_fine_stop = '0;
    for (int c = 0; c < NCH; c++) begin
      in_coarse[c*COARSE_W +: COARSE_W] = b_coarse[c];
      in_fine_start[c*FINE_W +: FINE_W] = b_start[c];
      in_fine_stop[c*FINE_W +: FINE_W]  = b_stop[c];
    end
  end

  always #5 clk = ~clk;

  count_combiner #(.NCH(NCH), .COARSE_W(COARSE_W), .FINE_BITS(FINE_BITS), .FINE_W(FINE_W),
                   .OUT_W(OUT_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_coarse(in_coarse),
    .in_fine_start(in_fine_start), .in_fine_stop(in_fine_stop), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .out_count(out_count), .out_ovf(out_ovf),
    .drop_count(drop_count));

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit     m_full [NCH];
  longint m_co [NCH], m_st [NCH], m_sp [NCH];
  int     m_rr;
  bit     m_ov;
  int     m_chan;
  longint m_cnt;
  bit     m_ovf;
  int     m_drop [NCH];

  task automatic calc(input longint co, input longint st, input longint sp, input bit md,
                      output longint cnt, output bit ovf);
    longint sum, maxv;
    maxv = (64'sd1 <<< OUT_W) - 1;
    sum  = co * (64'sd1 <<< FINE_BITS) + st - (md ? sp : 0);
    if (sum > maxv)   begin cnt = maxv; ovf = 1'b1; end
    else if (sum < 0) begin cnt = 0;    ovf = 1'b1; end
    else              begin cnt = sum;  ovf = 1'b0; end
  endtask

  // Advance model with the inputs currently applied, then step one clock.
  task automatic tick();
    int g;
    longint cnt;
    bit ovf;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin m_full[c] = 0; m_drop[c] = 0; end
      m_rr = 0; m_ov = 0; m_chan = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      g = -1;
      if (!m_ov || out_ready) begin
        for (int i = 0; i < NCH; i++) begin
          int c = (m_rr + i) % NCH;
          if (g < 0 && m_full[c]) g = c;
        end
      end
      if (g >= 0) begin
        calc(m_co[g], m_st[g], m_sp[g], mode, cnt, ovf);
        m_ov = 1; m_chan = g; m_cnt = cnt; m_ovf = ovf;
        m_rr = (g + 1) % NCH; m_full[g] = 0;
      end else if (out_ready) begin
        m_ov = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[c]) begin
          if (!m_full[c]) begin
            m_full[c] = 1; m_co[c] = b_coarse[c]; m_st[c] = b_start[c]; m_sp[c] = b_stop[c];
          end else if (m_drop[c] < 255) begin
            m_drop[c]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input longint co, input int st, input int sp);
    b_coarse[c] = COARSE_W'(co); b_start[c] = FINE_W'(st); b_stop[c] = FINE_W'(sp);
  endtask

  task automatic pulse(input logic [NCH-1:0] mask);
    in_valid = mask; tick(); in_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = '1; out_ready = 0; mode = 0;
    tick(); tick();
    rst = 0; in_valid = '0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_chan !== '0) begin n_errors++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    n_checks++; if (out_count !== '0) begin n_errors++; $display("FAIL reset_count got %0h want 0", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
    n_checks++; if (drop_count !== '0) begin n_errors++; $display("FAIL reset_drop got %0h want 0", drop_count); end
    out_ready = 1; tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_in_valid_ignored got %b want 0", out_valid); end
  endtask

  task automatic test_legacy();
    mode = 0; set_ch(0, 100, 5, 0);
    pulse(4'b0001);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL legacy_lat1 got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL legacy_valid got %b want 1", out_valid); end
    n_checks++; if (out_chan !== 2'd0) begin n_errors++; $display("FAIL legacy_chan got %0d want 0", out_chan); end
    n_checks++; if (out_count !== 32'd805) begin n_errors++; $display("FAIL legacy_count got %0d want 805", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_errors++; $display("FAIL legacy_ovf got %b want 0", out_ovf); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL legacy_consumed got %b want 0", out_valid); end
  endtask

  task automatic test_diff();
    mode = 1; set_ch(2, 100, 2, 7);
    pulse(4'b0100); tick();
    n_checks++; if (out_chan !== 2'd2) begin n_errors++; $display("FAIL diff_chan got %0d want 2", out_chan); end
    n_checks++; if (out_count !== 32'd795 || out_ovf !== 1'b0) begin n_errors++; $display("FAIL diff_count got %0d/%b want 795/0", out_count, out_ovf); end
    set_ch(2, 0, 1, 4);
    pulse(4'b0100); tick();
    n_checks++; if (out_count !== 32'd0 || out_ovf !== 1'b1) begin n_errors++; $display("FAIL diff_underflow got %0d/%b want 0/1", out_count, out_ovf); end
    set_ch(2, 0, 4, 4);
    pulse(4'b0100); tick();
    n_checks++; if (out_count !== 32'd0 || out_ovf !== 1'b0) begin n_errors++; $display("FAIL diff_zero got %0d/%b want 0/0", out_count, out_ovf); end
    tick();
  endtask

  task automatic test_overflow();
    mode = 0; set_ch(0, 64'h2000_0000, 0, 0);
    pulse(4'b0001); tick();
    n_checks++; if (out_count !== 32'hFFFF_FFFF || out_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_clamp got %0h/%b want ffffffff/1", out_count, out_ovf); end
    set_ch(0, 64'h1FFF_FFFF, 7, 9);
    pulse(4'b0001); tick();
    n_checks++; if (out_count !== 32'hFFFF_FFFF || out_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_edge got %0h/%b want ffffffff/0", out_count, out_ovf); end
    tick();
  endtask

  task automatic test_fairness();
    rst = 1; tick(); rst = 0;
    out_ready = 1; mode = 0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, c + 1 + b, c, 0);
      pulse('1);
      for (int k = 0; k < NCH; k++) begin
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_chan !== CH_W'(k) || out_count !== OUT_W'((k + 1 + b) * 8 + k)) begin
          n_errors++;
          $display("FAIL fair_order got v%b ch%0d cnt%0d want v1 ch%0d cnt%0d", out_valid, out_chan, out_count, k, (k + 1 + b) * 8 + k);
        end
      end
      repeat (5) tick();
    end
    n_checks++; if (drop_count !== '0) begin n_errors++; $display("FAIL fair_drop got %0h want 0", drop_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; mode = 0;
    set_ch(1, 1, 0, 0); in_valid = 4'b0010; tick();
    set_ch(1, 2, 0, 0); tick();
    set_ch(1, 3, 0, 0); tick();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_count !== 32'd8) begin n_errors++; $display("FAIL bp_stall_hold got v%b cnt%0d want v1 cnt8", out_valid, out_count); end
      if (k < 3) tick();
    end
    out_ready = 1; tick();
    n_checks++; if (out_valid !== 1'b1 || out_count !== 32'd16) begin n_errors++; $display("FAIL bp_second got v%b cnt%0d want v1 cnt16", out_valid, out_count); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    n_checks++; if (drop_count[1*DROP_W +: DROP_W] !== 8'd1) begin n_errors++; $display("FAIL bp_drop got %0d want 1", drop_count[1*DROP_W +: DROP_W]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; mode = 0;
    set_ch(3, 7, 0, 0); pulse(4'b1000); tick();
    set_ch(3, 9, 0, 0); pulse(4'b1000);
    n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd3) begin n_errors++; $display("FAIL rmid_pre got v%b ch%0d want v1 ch3", out_valid, out_chan); end
    set_ch(0, 20, 0, 0);
    rst = 1; in_valid = 4'b0001; tick();
    rst = 0; in_valid = '0;
    n_checks++;
    if (out_valid !== 1'b0 || out_chan !== '0 || out_count !== '0 || out_ovf !== 1'b0 || drop_count !== '0) begin
      n_errors++;
      $display("FAIL rmid_clear got v%b ch%0d cnt%0d ovf%b drop%0h want all 0", out_valid, out_chan, out_count, out_ovf, drop_count);
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_no_stale got %b want 0", out_valid); end
    end
    set_ch(0, 50, 1, 0); pulse(4'b0001);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_lat1 got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_count !== 32'd401) begin n_errors++; $display("FAIL rmid_fresh got v%b ch%0d cnt%0d want v1 ch0 cnt401", out_valid, out_chan, out_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1; mode = 0;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 10 + k, 0, 0);
      in_valid = (k < 4) ? 4'b0001 : 4'b0000;
      tick();
      if (k >= 1) begin
        n_checks++; if (out_valid !== 1'b1 || out_count !== OUT_W'((10 + k - 1) * 8)) begin n_errors++; $display("FAIL b2b_count got v%b cnt%0d want v1 cnt%0d", out_valid, out_count, (10 + k - 1) * 8); end
      end
    end
    in_valid = '0; tick();
    n_checks++; if (drop_count[DROP_W-1:0] !== 8'd0) begin n_errors++; $display("FAIL b2b_drop got %0d want 0", drop_count[DROP_W-1:0]); end
  endtask

  task automatic test_drop_sat();
    rst = 1; tick(); rst = 0;
    out_ready = 0; mode = 0; set_ch(2, 5, 0, 0);
    in_valid = 4'b0100;
    repeat (270) tick();
    in_valid = '0;
    n_checks++; if (drop_count[2*DROP_W +: DROP_W] !== 8'hFF) begin n_errors++; $display("FAIL drop_sat got %0d want 255", drop_count[2*DROP_W +: DROP_W]); end
    n_checks++; if (drop_count[0 +: DROP_W] !== 8'd0) begin n_errors++; $display("FAIL drop_other got %0d want 0", drop_count[0 +: DROP_W]); end
  endtask

  task automatic test_random();
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) begin
        in_valid[c] = ($urandom_range(0, 9) < 3);
        case ($urandom_range(0, 3))
          0:       b_coarse[c] = COARSE_W'($urandom);
          1:       b_coarse[c] = COARSE_W'($urandom_range(0, 2));
          2:       b_coarse[c] = 32'h1FFF_FFFF + COARSE_W'($urandom_range(0, 2));
          default: b_coarse[c] = COARSE_W'($urandom_range(0, 5000));
        endcase
        b_start[c] = FINE_W'($urandom);
        b_stop[c]  = FINE_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      tick();
      n_checks++;
      if (out_valid !== m_ov) begin
        n_errors++; $display("FAIL rand_valid cyc%0d got %b want %b", n, out_valid, m_ov);
      end else if (m_ov && (out_chan !== CH_W'(m_chan) || out_count !== OUT_W'(m_cnt) || out_ovf !== m_ovf)) begin
        n_errors++;
        $display("FAIL rand_result cyc%0d got ch%0d cnt%0h ovf%b want ch%0d cnt%0h ovf%b", n, out_chan, out_count, out_ovf, m_chan, m_cnt, m_ovf);
      end
    end
    in_valid = '0;
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (drop_count[c*DROP_W +: DROP_W] !== DROP_W'(m_drop[c])) begin
        n_errors++; $display("FAIL rand_drop ch%0d got %0d want %0d", c, drop_count[c*DROP_W +: DROP_W], m_drop[c]);
      end
    end
  endtask

  initial begin
    rst = 1; mode = 0; out_ready = 0; in_valid = '0;
    for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 0);
    test_reset();
    test_legacy();
    test_diff();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_drop_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
